// File: rtl/ppu_mem_preloader_pkg.sv
// Shared preload listings for the PPU: VRAM and OAM (address, value) pairs,
// default pair counts, the sequencer state encoding and listing lookups.
package ppu_preload_pkg;

  localparam int VRAM_PAIRS_DEF = 53;
  localparam int OAM_PAIRS_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_V_WR  = 3'd1,
    ST_V_RD  = 3'd2,
    ST_V_CMP = 3'd3,
    ST_O_WR  = 3'd4,
    ST_O_RD  = 3'd5,
    ST_O_CMP = 3'd6,
    ST_FIN   = 3'd7
  } preload_state_e;

  // Pair n is elements 2n (address) and 2n+1 (value); tail is zero padding.
  localparam int VRAM_LIST [128] = '{
    'h3F00, 'h0F, 'h3F01, 'h30, 'h3F02, 'h16, 'h3F03, 'h27,
    'h3F04, 'h0F, 'h3F05, 'h1A, 'h3F06, 'h2A, 'h3F07, 'h3A,
    'h3F08, 'h0F, 'h3F09, 'h11, 'h3F0A, 'h21, 'h3F0B, 'h31,
    'h3F0C, 'h0F, 'h3F0D, 'h14, 'h3F0E, 'h24, 'h3F0F, 'h34,
    'h3F10, 'h0F, 'h3F11, 'h16, 'h3F12, 'h27, 'h3F13, 'h38,
    'h3F14, 'h0F, 'h3F15, 'h0C, 'h3F16, 'h1C, 'h3F17, 'h2C,
    'h3F18, 'h0F, 'h3F19, 'h05, 'h3F1A, 'h15, 'h3F1B, 'h25,
    'h3F1C, 'h0F, 'h3F1D, 'h02, 'h3F1E, 'h12, 'h3F1F, 'h22,
    'h23C0, 'h0D, 'h23C1, 'h55, 'h23C2, 'hAA, 'h23C3, 'hFF,
    'h23C4, 'h00, 'h23C5, 'h11, 'h23C6, 'h22, 'h23C7, 'h33,
    'h23C8, 'h44, 'h23C9, 'h55, 'h23CA, 'h66, 'h23CB, 'h77,
    'h23CC, 'h88, 'h23CD, 'h99, 'h23CE, 'hAA, 'h23CF, 'hBB,
    'h2000, 'h80, 'h2001, 'h1E, 'h2400, 'h01, 'h2041, 'h41,
    'h6042, 'h142,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

  localparam int OAM_LIST [64] = '{
    'h00, 'h20, 'h01, 'h01, 'h02, 'h00, 'h03, 'h10,
    'h04, 'h20, 'h05, 'h02, 'h06, 'h00, 'h07, 'h18,
    'h08, 'h28, 'h09, 'h03, 'h0A, 'h01, 'h0B, 'h10,
    'h0C, 'h28, 'h0D, 'h04, 'h0E, 'h01, 'h0F, 'h18,
    'h10, 'h30, 'h11, 'h05, 'h12, 'h02, 'h13, 'h20,
    'h14, 'h30, 'h15, 'h06, 'h16, 'h02, 'h17, 'h28,
    'h18, 'h38, 'h19, 'h07, 'h1A, 'h03, 'h1B, 'h30,
    'h1C, 'h38, 'h1D, 'h08, 'h1E, 'h43, 'h1F, 'h38
  };

  // Lookups return 0 past the end of a listing.
  function automatic logic [13:0] vram_entry_addr(input logic [6:0] n);
    logic [13:0] a;
    a = '0;
    if (n < 7'(VRAM_PAIRS_DEF)) a = 14'(VRAM_LIST[{n[5:0], 1'b0}]);
    return a;
  endfunction

  function automatic logic [7:0] vram_entry_data(input logic [6:0] n);
    logic [7:0] d;
    d = '0;
    if (n < 7'(VRAM_PAIRS_DEF)) d = 8'(VRAM_LIST[{n[5:0], 1'b1}]);
    return d;
  endfunction

  function automatic logic [7:0] oam_entry_addr(input logic [6:0] n);
    logic [7:0] a;
    a = '0;
    if (n < 7'(OAM_PAIRS_DEF)) a = 8'(OAM_LIST[{n[4:0], 1'b0}]);
    return a;
  endfunction

  function automatic logic [7:0] oam_entry_data(input logic [6:0] n);
    logic [7:0] d;
    d = '0;
    if (n < 7'(OAM_PAIRS_DEF)) d = 8'(OAM_LIST[{n[4:0], 1'b1}]);
    return d;
  endfunction

endpackage

// File: rtl/ppu_mem_preloader_if.sv
// VRAM and OAM request/response port bundle between the preloader (master)
// and the memories (slave).
interface ppu_mem_preloader_if;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic        vram_ready;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        oam_re;
  logic [7:0]  oam_rdata;

  modport master (
    output vram_addr, vram_wdata, vram_we, vram_re,
    output oam_addr, oam_wdata, oam_we, oam_re,
    input  vram_ready, vram_rdata, oam_rdata
  );

  modport slave (
    input  vram_addr, vram_wdata, vram_we, vram_re,
    input  oam_addr, oam_wdata, oam_we, oam_re,
    output vram_ready, vram_rdata, oam_rdata
  );
endinterface

// File: rtl/ppu_mem_preloader.sv
// Walks the VRAM then OAM preload listings, writing each entry and optionally
// reading it back; holds the PPU renderer off while a load is running.
//
// state | meaning
// IDLE  | waiting for start
// V_WR  | VRAM write request, held until vram_ready
// V_RD  | VRAM readback request, held until vram_ready
// V_CMP | compare VRAM read data with listing value
// O_WR  | OAM write
// O_RD  | OAM readback
// O_CMP | compare OAM read data with listing value
// FIN   | raise done, return to IDLE
module ppu_mem_preloader
  import ppu_preload_pkg::*;
#(
  parameter int VRAM_PAIRS = VRAM_PAIRS_DEF,
  parameter int OAM_PAIRS  = OAM_PAIRS_DEF,
  parameter bit VERIFY     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  ppu_mem_preloader_if.master        mem,
  output logic                       busy,
  output logic                       hold_ppu,
  output logic                       done,
  output logic                       error,
  output logic [6:0]                 err_index
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_V_WR  = ST_V_WR;
  localparam logic [2:0] S_V_RD  = ST_V_RD;
  localparam logic [2:0] S_V_CMP = ST_V_CMP;
  localparam logic [2:0] S_O_WR  = ST_O_WR;
  localparam logic [2:0] S_O_RD  = ST_O_RD;
  localparam logic [2:0] S_O_CMP = ST_O_CMP;
  localparam logic [2:0] S_FIN   = ST_FIN;

  localparam logic [6:0] V_CNT = 7'(VRAM_PAIRS);
  localparam logic [6:0] O_CNT = 7'(OAM_PAIRS);

  logic [2:0]  state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [6:0]  err_index_q, err_index_d;

  logic [13:0] v_addr;
  logic [7:0]  v_data, o_addr, o_data;
  logic [6:0]  idx_inc;
  logic        v_adv, o_adv;

  assign v_addr  = vram_entry_addr(idx_q);
  assign v_data  = vram_entry_data(idx_q);
  assign o_addr  = oam_entry_addr(idx_q);
  assign o_data  = oam_entry_data(idx_q);
  assign idx_inc = idx_q + 7'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    v_adv       = 1'b0;
    o_adv       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = '0;
          idx_d       = '0;
          if (VRAM_PAIRS > 0)     state_d = S_V_WR;
          else if (OAM_PAIRS > 0) state_d = S_O_WR;
          else                    state_d = S_FIN;
        end
      end
      S_V_WR: begin
        if (mem.vram_ready) begin
          if (VERIFY) state_d = S_V_RD;
          else        v_adv   = 1'b1;
        end
      end
      S_V_RD: begin
        if (mem.vram_ready) state_d = S_V_CMP;
      end
      S_V_CMP: begin
        if (mem.vram_rdata != v_data) begin
          error_d = 1'b1;
          if (!error_q) err_index_d = idx_q;
        end
        v_adv = 1'b1;
      end
      S_O_WR: begin
        if (VERIFY) state_d = S_O_RD;
        else        o_adv   = 1'b1;
      end
      S_O_RD: state_d = S_O_CMP;
      S_O_CMP: begin
        if (mem.oam_rdata != o_data) begin
          error_d = 1'b1;
          if (!error_q) err_index_d = V_CNT + idx_q;
        end
        o_adv = 1'b1;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Step to the next entry, or on to the next section when a listing ends.
    if (v_adv) begin
      if (idx_inc == V_CNT) begin
        idx_d   = '0;
        state_d = (OAM_PAIRS > 0) ? S_O_WR : S_FIN;
      end else begin
        idx_d   = idx_inc;
        state_d = S_V_WR;
      end
    end
    if (o_adv) begin
      if (idx_inc == O_CNT) begin
        idx_d   = '0;
        state_d = S_FIN;
      end else begin
        idx_d   = idx_inc;
        state_d = S_O_WR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  always_comb begin
    mem.vram_addr  = '0;
    mem.vram_wdata = '0;
    mem.vram_we    = 1'b0;
    mem.vram_re    = 1'b0;
    mem.oam_addr   = '0;
    mem.oam_wdata  = '0;
    mem.oam_we     = 1'b0;
    mem.oam_re     = 1'b0;
    case (state_q)
      S_V_WR, S_V_RD: begin
        mem.vram_addr  = v_addr;
        mem.vram_wdata = v_data;
        mem.vram_we    = (state_q == S_V_WR);
        mem.vram_re    = (state_q == S_V_RD);
      end
      S_O_WR, S_O_RD: begin
        mem.oam_addr  = o_addr;
        mem.oam_wdata = o_data;
        mem.oam_we    = (state_q == S_O_WR);
        mem.oam_re    = (state_q == S_O_RD);
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign hold_ppu  = busy;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_ppu_mem_preloader.sv
// Directed bench for ppu_mem_preloader: one VERIFY=1 and one VERIFY=0 instance
// driving behavioural VRAM/OAM models.
module tb_ppu_mem_preloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1, rst0 = 1'b1, start1 = 1'b0, start0 = 1'b0;
  logic busy1, hold1, done1, error1, busy0, hold0, done0, error0;
  logic [6:0] eidx1, eidx0;
  logic ready_drv = 1'b1;
  logic poison = 1'b0, corrupt_en = 1'b0;
  int tests = 0, fails = 0;
  int wr_cnt1 = 0;

  ppu_mem_preloader_if m1 ();
  ppu_mem_preloader_if m0 ();
  assign m1.vram_ready = ready_drv;
  assign m0.vram_ready = ready_drv;

  ppu_mem_preloader #(.VERIFY(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .mem(m1),
    .busy(busy1), .hold_ppu(hold1), .done(done1), .error(error1), .err_index(eidx1)
  );
  ppu_mem_preloader #(.VERIFY(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .mem(m0),
    .busy(busy0), .hold_ppu(hold0), .done(done0), .error(error0), .err_index(eidx0)
  );

  logic [7:0] vram1 [16384];
  logic [7:0] oam1  [256];
  logic [7:0] vram0 [16384];
  logic [7:0] oam0  [256];

  always @(posedge clk) begin
    if (m1.vram_we && m1.vram_ready) begin
      vram1[m1.vram_addr] <= (corrupt_en && (m1.vram_addr == 14'h2001 || m1.vram_addr == 14'h2041))
                             ? ~m1.vram_wdata : m1.vram_wdata;
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (m1.vram_re && m1.vram_ready) m1.vram_rdata <= vram1[m1.vram_addr];
    if (m1.oam_we) oam1[m1.oam_addr] <= m1.oam_wdata;
    if (m1.oam_re) m1.oam_rdata <= oam1[m1.oam_addr];
    if (m0.vram_we && m0.vram_ready) vram0[m0.vram_addr] <= m0.vram_wdata;
    if (m0.vram_re && m0.vram_ready) m0.vram_rdata <= vram0[m0.vram_addr];
    if (m0.oam_we) oam0[m0.oam_addr] <= m0.oam_wdata;
    if (m0.oam_re) m0.oam_rdata <= oam0[m0.oam_addr];
    if (poison) begin
      vram1[14'h23C0] <= 8'hEE;
      vram1[14'h3F13] <= 8'hEE;
      vram1[14'h2042] <= 8'hEE;
      oam1[8'h1F]     <= 8'hEE;
      vram0[14'h23C0] <= 8'hEE;
      vram0[14'h2042] <= 8'hEE;
      oam0[8'h1F]     <= 8'hEE;
    end
  end

  logic [52:0] outs1, outs0;
  assign outs1 = {busy1, hold1, done1, error1, eidx1, m1.vram_addr, m1.vram_wdata, m1.vram_we,
                  m1.vram_re, m1.oam_addr, m1.oam_wdata, m1.oam_we, m1.oam_re};
  assign outs0 = {busy0, hold0, done0, error0, eidx0, m0.vram_addr, m0.vram_wdata, m0.vram_we,
                  m0.vram_re, m0.oam_addr, m0.oam_wdata, m0.oam_we, m0.oam_re};

  logic        s_busy, s_hold, s_done, s_we, s_re, s_owe, s_ore;
  logic [13:0] s_addr;
  logic [7:0]  s_data;
  int  r_cycles, r_stalls, r_unstable, r_both, r_hold_bad;
  bit  r_re_seen, r_done_early, r_timeout;

  task automatic sample(input bit v0);
    if (v0) begin
      s_busy = busy0; s_hold = hold0; s_done = done0; s_we = m0.vram_we; s_re = m0.vram_re;
      s_owe = m0.oam_we; s_ore = m0.oam_re; s_addr = m0.vram_addr; s_data = m0.vram_wdata;
    end else begin
      s_busy = busy1; s_hold = hold1; s_done = done1; s_we = m1.vram_we; s_re = m1.vram_re;
      s_owe = m1.oam_we; s_ore = m1.oam_re; s_addr = m1.vram_addr; s_data = m1.vram_wdata;
    end
  endtask

  // Pulses start, then counts busy cycles until busy falls (returns in FIN).
  task automatic run_load(input bit v0, input bit stall, input int repulse_at);
    bit prev_st;
    logic [13:0] pa;
    logic [7:0] pd;
    logic pwe, pre;
    r_cycles = 0; r_stalls = 0; r_unstable = 0; r_both = 0; r_hold_bad = 0;
    r_re_seen = 0; r_timeout = 0; prev_st = 0; pa = '0; pd = '0; pwe = 0; pre = 0;
    @(negedge clk);
    if (v0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    sample(v0);
    r_done_early = s_done;
    while (s_busy) begin
      if (prev_st && (s_addr !== pa || s_data !== pd || s_we !== pwe || s_re !== pre)) r_unstable++;
      if ((s_we && s_re) || (s_owe && s_ore)) r_both++;
      if (s_hold !== s_busy) r_hold_bad++;
      if (s_re || s_ore) r_re_seen = 1;
      ready_drv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_st = (s_we || s_re) && !ready_drv;
      if (prev_st) r_stalls++;
      pa = s_addr; pd = s_data; pwe = s_we; pre = s_re;
      r_cycles++;
      if (r_cycles == repulse_at) begin
        if (v0) start0 = 1'b1; else start1 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      if (r_cycles > 3000) begin
        r_timeout = 1;
        break;
      end
      @(negedge clk);
      sample(v0);
    end
    ready_drv = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic do_poison();
    @(negedge clk); poison = 1'b1;
    @(negedge clk); poison = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst0 = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (outs1 !== '0) begin fails++; $display("FAIL reset_outs_v1 got %h expected 0", outs1); end
    tests++; if (outs0 !== '0) begin fails++; $display("FAIL reset_outs_v0 got %h expected 0", outs0); end
    tests++; if (dut1.state_q !== 3'd0) begin fails++; $display("FAIL reset_state got %0d expected 0", dut1.state_q); end
    rst1 = 1'b0; rst0 = 1'b0;
    @(negedge clk);
    tests++; if (outs1 !== '0) begin fails++; $display("FAIL reset_release got %h expected 0", outs1); end
  endtask

  task automatic test_full_load();
    int wr0;
    do_poison();
    wr0 = wr_cnt1;
    run_load(1'b0, 1'b0, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL full_timeout got busy after %0d cycles expected 255", r_cycles); end
    tests++; if (r_cycles != 255) begin fails++; $display("FAIL full_busy_cycles got %0d expected 255", r_cycles); end
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL full_done_in_fin got %b expected 0", done1); end
    @(negedge clk);
    tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL full_done got %b expected 1", done1); end
    tests++; if (error1 !== 1'b0) begin fails++; $display("FAIL full_error got %b expected 0", error1); end
    tests++; if (vram1[14'h23C0] !== 8'h0D) begin fails++; $display("FAIL full_vram_23c0 got %h expected 0d", vram1[14'h23C0]); end
    tests++; if (vram1[14'h2400] !== 8'h01) begin fails++; $display("FAIL full_vram_2400 got %h expected 01", vram1[14'h2400]); end
    tests++; if (vram1[14'h2042] !== 8'h42) begin fails++; $display("FAIL full_vram_mask got %h expected 42", vram1[14'h2042]); end
    tests++; if (oam1[8'h1F] !== 8'h38) begin fails++; $display("FAIL full_oam_1f got %h expected 38", oam1[8'h1F]); end
    tests++; if (oam1[8'h00] !== 8'h20) begin fails++; $display("FAIL full_oam_00 got %h expected 20", oam1[8'h00]); end
    tests++; if (wr_cnt1 - wr0 != 53) begin fails++; $display("FAIL full_vram_writes got %0d expected 53", wr_cnt1 - wr0); end
    tests++; if (r_both != 0 || r_hold_bad != 0) begin fails++; $display("FAIL full_req_excl got both=%0d hold_bad=%0d expected 0", r_both, r_hold_bad); end
  endtask

  task automatic test_stall();
    do_poison();
    run_load(1'b0, 1'b1, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL stall_timeout got %0d cycles expected end", r_cycles); end
    tests++; if (r_cycles != 255 + r_stalls) begin fails++; $display("FAIL stall_cycles got %0d expected %0d", r_cycles, 255 + r_stalls); end
    tests++; if (r_stalls == 0) begin fails++; $display("FAIL stall_count got %0d expected nonzero", r_stalls); end
    tests++; if (r_unstable != 0) begin fails++; $display("FAIL stall_stable got %0d changes expected 0", r_unstable); end
    @(negedge clk);
    tests++; if (done1 !== 1'b1 || error1 !== 1'b0) begin fails++; $display("FAIL stall_status got done=%b err=%b expected 1/0", done1, error1); end
    tests++; if (vram1[14'h23C0] !== 8'h0D) begin fails++; $display("FAIL stall_vram_23c0 got %h expected 0d", vram1[14'h23C0]); end
    tests++; if (vram1[14'h3F13] !== 8'h38) begin fails++; $display("FAIL stall_vram_3f13 got %h expected 38", vram1[14'h3F13]); end
    tests++; if (oam1[8'h1F] !== 8'h38) begin fails++; $display("FAIL stall_oam_1f got %h expected 38", oam1[8'h1F]); end
  endtask

  task automatic test_corrupt();
    int wr0;
    corrupt_en = 1'b1;
    wr0 = wr_cnt1;
    run_load(1'b0, 1'b0, -1);
    tests++; if (r_done_early !== 1'b0) begin fails++; $display("FAIL corrupt_done_clear got %b expected 0", r_done_early); end
    tests++; if (r_cycles != 255) begin fails++; $display("FAIL corrupt_cycles got %0d expected 255", r_cycles); end
    @(negedge clk);
    corrupt_en = 1'b0;
    tests++; if (done1 !== 1'b1 || error1 !== 1'b1) begin fails++; $display("FAIL corrupt_status got done=%b err=%b expected 1/1", done1, error1); end
    tests++; if (eidx1 !== 7'd49) begin fails++; $display("FAIL corrupt_err_index got %0d expected 49", eidx1); end
    tests++; if (wr_cnt1 - wr0 != 53) begin fails++; $display("FAIL corrupt_writes got %0d expected 53", wr_cnt1 - wr0); end
    tests++; if (vram1[14'h2001] !== 8'hE1) begin fails++; $display("FAIL corrupt_vram_2001 got %h expected e1", vram1[14'h2001]); end
    tests++; if (vram1[14'h2400] !== 8'h01) begin fails++; $display("FAIL corrupt_vram_2400 got %h expected 01", vram1[14'h2400]); end
  endtask

  task automatic test_reset_midload();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (99) @(negedge clk);
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL midrst_busy got %b expected 1", busy1); end
    rst1 = 1'b1;
    @(negedge clk);
    tests++; if (outs1 !== '0) begin fails++; $display("FAIL midrst_outs got %h expected 0", outs1); end
    rst1 = 1'b0;
    run_load(1'b0, 1'b0, -1);
    tests++; if (r_cycles != 255) begin fails++; $display("FAIL midrst_reload_cycles got %0d expected 255", r_cycles); end
    @(negedge clk);
    tests++; if (done1 !== 1'b1 || error1 !== 1'b0) begin fails++; $display("FAIL midrst_status got done=%b err=%b expected 1/0", done1, error1); end
  endtask

  task automatic test_restart_ignored();
    run_load(1'b0, 1'b0, 50);
    tests++; if (r_cycles != 255) begin fails++; $display("FAIL restart_cycles got %0d expected 255", r_cycles); end
    @(negedge clk);
    tests++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin fails++; $display("FAIL restart_status got done=%b busy=%b expected 1/0", done1, busy1); end
  endtask

  task automatic test_no_verify();
    do_poison();
    run_load(1'b1, 1'b0, 40);
    tests++; if (r_cycles != 85) begin fails++; $display("FAIL nover_cycles got %0d expected 85", r_cycles); end
    tests++; if (r_re_seen) begin fails++; $display("FAIL nover_read got %b expected 0", r_re_seen); end
    tests++; if (r_hold_bad != 0) begin fails++; $display("FAIL nover_hold got %0d expected 0", r_hold_bad); end
    @(negedge clk);
    tests++; if (done0 !== 1'b1 || error0 !== 1'b0 || eidx0 !== 7'd0) begin
      fails++; $display("FAIL nover_status got done=%b err=%b idx=%0d expected 1/0/0", done0, error0, eidx0); end
    tests++; if (vram0[14'h23C0] !== 8'h0D) begin fails++; $display("FAIL nover_vram_23c0 got %h expected 0d", vram0[14'h23C0]); end
    tests++; if (vram0[14'h2042] !== 8'h42) begin fails++; $display("FAIL nover_vram_mask got %h expected 42", vram0[14'h2042]); end
    tests++; if (oam0[8'h1F] !== 8'h38) begin fails++; $display("FAIL nover_oam_1f got %h expected 38", oam0[8'h1F]); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_corrupt();
    test_reset_midload();
    test_restart_ignored();
    test_no_verify();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
